// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO UART responder: I/O page decode, register
// select bits, status bit positions and the TX state encoding.
package mmio_pkg;
   localparam int IO_PAGE_BIT_DEFAULT = 22;

   // Register select bits, counted from mem_addr[2]
   localparam int LEDS_BIT      = 0;
   localparam int UART_DAT_BIT  = 1;
   localparam int UART_CNTL_BIT = 2;

   localparam int BUSY_BIT      = 9;
   localparam int OVERRUN_BIT   = 8;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;
endpackage

// File: rtl/uart_tx_core.sv
// 8N1 transmitter: start bit goes out at the accepting edge, busy drops 10*DIV cycles later.
// No backpressure: start is only acted on in IDLE, and the caller gates it with busy.
module uart_tx_core
   import mmio_pkg::*;
#(
   parameter int DIV = 434
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       txd
);
   localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   tx_state_t     r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_busy;
   logic          r_txd;
   logic          w_cnt_end;

   assign w_cnt_end = (r_cnt == CNT_LAST);
   assign busy      = r_busy;
   assign txd       = r_txd;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= TX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_busy  <= 1'b0;
         r_txd   <= 1'b1;
      end else begin
         case (r_state)
            TX_IDLE: begin
               if (start) begin
                  r_state <= TX_START;
                  r_cnt   <= '0;
                  r_shift <= data;
                  r_busy  <= 1'b1;
                  r_txd   <= 1'b0;
               end
            end
            TX_START: begin
               if (w_cnt_end) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_state <= TX_DATA;
                  r_txd   <= r_shift[0];
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            TX_DATA: begin
               if (w_cnt_end) begin
                  r_cnt <= '0;
                  if (r_bit == 3'd7) begin
                     r_state <= TX_STOP;
                     r_txd   <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_txd   <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            TX_STOP: begin
               // busy falls on the edge that ends the stop bit
               if (w_cnt_end) begin
                  r_cnt   <= '0;
                  r_state <= TX_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= TX_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/mmio_uart_responder.sv
// I/O-page bus target (LEDs, UART data, UART status); reads return one cycle after rstrb.
// Writes to UART data while the transmitter is busy are dropped and flagged as overrun.
module mmio_uart_responder
   import mmio_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int BAUD_RATE   = 115200,
   parameter int LED_WIDTH   = 5,
   parameter int IO_PAGE_BIT = IO_PAGE_BIT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [31:0]          mem_addr,
   input  logic                 mem_rstrb,
   input  logic [31:0]          mem_wdata,
   input  logic [3:0]           mem_wmask,
   output logic [31:0]          mem_rdata,
   output logic [LED_WIDTH-1:0] leds,
   output logic                 txd
);
   localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;

   if (DIV < 2) begin : g_div_check
      $error("mmio_uart_responder: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
   end

   logic                 w_io_sel;
   logic [2:0]           w_sel;
   logic                 w_wr_lane0;
   logic                 w_wr_dat;
   logic                 w_start;
   logic                 w_ovr_set;
   logic                 w_rd;
   logic                 w_rd_cntl;
   logic                 w_busy;
   logic [31:0]          w_led_ext;
   logic [31:0]          w_cntl_val;
   logic [31:0]          w_rd_val;
   logic                 w_unused;

   logic [LED_WIDTH-1:0] r_leds;
   logic [7:0]           r_dat;
   logic                 r_overrun;
   logic [31:0]          r_rdata;

   assign w_io_sel   = mem_addr[IO_PAGE_BIT];
   assign w_sel      = mem_addr[4:2];
   assign w_wr_lane0 = w_io_sel && (|mem_wmask) && mem_wmask[0];
   assign w_wr_dat   = w_wr_lane0 && w_sel[UART_DAT_BIT];
   assign w_start    = w_wr_dat && !w_busy;
   assign w_ovr_set  = w_wr_dat && w_busy;
   assign w_rd       = mem_rstrb && w_io_sel;
   assign w_rd_cntl  = w_rd && w_sel[UART_CNTL_BIT];
   assign w_unused   = ^{mem_addr, mem_wdata};

   assign mem_rdata  = r_rdata;
   assign leds       = r_leds;

   // Selected registers are OR-ed so multi-hot addresses read a defined value
   always_comb begin
      w_led_ext                   = '0;
      w_led_ext[LED_WIDTH-1:0]    = r_leds;
      w_cntl_val                  = '0;
      w_cntl_val[BUSY_BIT]        = w_busy;
      w_cntl_val[OVERRUN_BIT]     = r_overrun;
      w_rd_val                    = '0;
      if (w_sel[LEDS_BIT])      w_rd_val = w_rd_val | w_led_ext;
      if (w_sel[UART_DAT_BIT])  w_rd_val = w_rd_val | {24'b0, r_dat};
      if (w_sel[UART_CNTL_BIT]) w_rd_val = w_rd_val | w_cntl_val;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_leds    <= '0;
         r_dat     <= '0;
         r_overrun <= 1'b0;
         r_rdata   <= '0;
      end else begin
         if (w_wr_lane0 && w_sel[LEDS_BIT]) r_leds <= mem_wdata[LED_WIDTH-1:0];
         if (w_start) r_dat <= mem_wdata[7:0];
         // A new overrun beats the read-to-clear on the same edge
         if (w_ovr_set)      r_overrun <= 1'b1;
         else if (w_rd_cntl) r_overrun <= 1'b0;
         if (w_rd) r_rdata <= w_rd_val;
      end
   end

   uart_tx_core #(
      .DIV (DIV)
   ) u_tx (
      .clk    (clk),
      .resetn (resetn),
      .start  (w_start),
      .data   (mem_wdata[7:0]),
      .busy   (w_busy),
      .txd    (txd)
   );
endmodule
